msf_low_time_scan: RTL and testbench
====================================

// Module: msf_low_time_scan
// PURPOSE
//  Scheduler that scans the per-second carrier-amplitude BRAM once per minute (or on demand) and
//  locates the quietest slot, i.e. the MSF/DCF second-marker carrier-off point. It derives the
//  low_time value fed to timing_control, so the one-second marker tracks the received phase.
//  It owns one read port of the second BRAM; the timing write port is untouched.
// PARAMETERS
//  ADDR_W       10  second-BRAM address width; slot index = carrier count >> LOW_SHIFT
//  DATA_W       32  amplitude word width, unsigned
//  RD_LATENCY   2   BRAM read latency in clk cycles, from bram_en to valid bram_rdata (1..4)
//  LOW_SHIFT    7   carrier pulses per slot = 2**LOW_SHIFT
//  SCAN_SECOND  0   second_counter value that triggers the automatic scan
//  MIN_CONTRAST 256 required (max - min) before a result is accepted
// PORTS
//  clk             in   1       adc clock
//  aresetn         in   1       asynchronous active-low reset
//  enable          in   1       0 = automatic triggers ignored; scan_start still honoured
//  scan_start      in   1       single-cycle request for an immediate scan
//  one_sec_marker  in   1       level from timing_control; rising edge = second boundary
//  second_counter  in   6       current second 0..59
//  msf_frequency   in   17      terminal carrier count (77499 for Frankfurt)
//  bram_addr       out  ADDR_W  second-BRAM read address
//  bram_en         out  1       second-BRAM read enable
//  bram_rdata      in   DATA_W  read data, RD_LATENCY after bram_en
//  low_time        out  17      {min_index, LOW_SHIFT zeros}, sized to 17 bits
//  low_time_valid  out  1       set after the first accepted scan; cleared only by reset
//  min_value       out  DATA_W  minimum amplitude from the last completed scan
//  scan_busy       out  1       high from the cycle after trigger to the scan_done cycle
//  scan_done       out  1       one-cycle pulse when a scan completes
//  scan_rejected   out  1       sticky: last scan failed MIN_CONTRAST; cleared by next accepted scan
// BEHAVIOUR
//  Reset: all outputs 0. The FSM goes to IDLE. min/max/index registers are cleared.
//  last_index = msf_frequency[16:LOW_SHIFT]. It is latched at trigger and stays stable through the scan.
//  Trigger: scan_start=1, or (enable & rising edge of one_sec_marker & second_counter==SCAN_SECOND).
//   Triggers while scan_busy are dropped; they are not queued.
//  FSM:
//   IDLE  -> ISSUE on trigger.
//   ISSUE: bram_en=1, bram_addr counts 0..last_index, one address per cycle. -> DRAIN after last_index.
//   DRAIN: bram_en=0 and wait RD_LATENCY cycles for the final data. -> DONE.
//   DONE:  register results, pulse scan_done. -> IDLE.
//  Compare pipeline: a shift register of valid+index, RD_LATENCY deep, is aligned to bram_rdata.
//   The first valid sample loads both min and max.
//   Strict < for min, so on ties the lowest index wins. Strict > for max.
//  Accept: if (max - min) >= MIN_CONTRAST, then low_time <= min_index << LOW_SHIFT,
//   min_value updates, low_time_valid <= 1, scan_rejected <= 0.
//   Otherwise low_time is held and scan_rejected <= 1. min_value updates in both cases.
//  Latency: scan_done follows the trigger by last_index + 1 + RD_LATENCY + 2 cycles.
//   For 77499 and RD_LATENCY=2 that is 605+1+2+2 = 610 cycles.
//  Outputs update only on the scan_done cycle, so timing_control never sees a partial result.
//  The subtraction is DATA_W bits unsigned; it cannot underflow because max >= min.
//  Edge cases:
//   - msf_frequency < 2**LOW_SHIFT gives last_index=0: a single-entry scan, which is always rejected.
//   - aresetn low mid-scan aborts immediately. Outputs clear and no scan_done is issued.
//   - A one_sec_marker edge and scan_start in the same cycle produce one scan.
// STRUCTURE
//  Shared package msf_pkg holds MSF_CARRIER_FRANKFURT=77499, MSF_SLOT_SHIFT=7, SECONDS_MINUTE=59
//   and the scan-state enum (IDLE, ISSUE, DRAIN, DONE).
//  One sub-module, msf_minmax_track: a streaming min/max/argmin unit with valid, index, data and clear inputs.
// TESTING
//  1. Ramp the BRAM with 1000-i except slot 300 = 5, then scan_start
//     -> low_time=38400, min_value=5, scan_done at cycle 610.
//  2. Two equal minima (=0) at slots 100 and 400 -> low_time=12800; lowest index wins.
//  3. Flat BRAM: all 500, then 600 at slot 10 -> scan_rejected=1 and low_time keeps its previous value.
//  4. enable=1, step second_counter through 59->0 with one_sec_marker edges
//     -> exactly one scan starts at second 0; none start at other seconds.
//  5. Assert scan_start 5 times during a scan -> only one scan_done pulse.
//  6. Drop aresetn at address 200 -> outputs 0 and FSM in IDLE; a later scan_start completes normally.

Source files
------------

// File: rtl/msf_pkg.sv
// Shared constants and scan-state encoding for the MSF/DCF
// low-time scheduler.
package msf_pkg;

    localparam int MSF_CARRIER_FRANKFURT = 77499;
    localparam int MSF_SLOT_SHIFT        = 7;
    localparam int SECONDS_MINUTE        = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // Slot index to carrier count: {idx, shift zeros}.
    function automatic logic [16:0] slot_to_carrier(
        input logic [16:0] idx,
        input int          shift
    );
        return idx << shift;
    endfunction

endpackage

// File: rtl/msf_minmax_track.sv
// Streaming min/max/argmin tracker. The first valid sample
// after clear loads both extremes; ties keep the lowest index.
module msf_minmax_track #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] index_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o,
    output logic [ADDR_W-1:0] min_idx_o
);

    logic              first_q;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;
    logic [ADDR_W-1:0] idx_q;

    // Fold each valid sample into the running extremes.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            first_q <= 1'b1;
            min_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else if (clear_i) begin
            first_q <= 1'b1;
        end else if (valid_i) begin
            first_q <= 1'b0;
            if (first_q || (data_i < min_q)) begin
                min_q <= data_i;
                idx_q <= index_i;
            end
            if (first_q || (data_i > max_q)) begin
                max_q <= data_i;
            end
        end
    end

    assign min_o     = min_q;
    assign max_o     = max_q;
    assign min_idx_o = idx_q;

endmodule

// File: rtl/msf_low_time_scan.sv
// Scans the per-second amplitude BRAM for the quietest slot and
// publishes it as low_time for the one-second marker.
module msf_low_time_scan
    import msf_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 2,
    parameter int LOW_SHIFT    = MSF_SLOT_SHIFT,
    parameter int SCAN_SECOND  = 0,
    parameter int MIN_CONTRAST = 256
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              scan_start,
    input  logic              one_sec_marker,
    input  logic [5:0]        second_counter,
    input  logic [16:0]       msf_frequency,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [16:0]       low_time,
    output logic              low_time_valid,
    output logic [DATA_W-1:0] min_value,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              scan_rejected
);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [2:0]        drain_q, drain_d;
    logic              marker_q;
    logic              busy_q;
    logic              done_q;
    logic [16:0]       low_time_q;
    logic              lt_valid_q;
    logic [DATA_W-1:0] min_value_q;
    logic              rejected_q;

    logic [RD_LATENCY-1:0] vld_sr_q;
    logic [ADDR_W-1:0]     idx_sr_q [RD_LATENCY];

    logic              trigger;
    logic              clear;
    logic [ADDR_W-1:0] last_index;
    logic [DATA_W-1:0] trk_min;
    logic [DATA_W-1:0] trk_max;
    logic [ADDR_W-1:0] trk_idx;
    logic [DATA_W-1:0] span;
    logic              accept;

    assign last_index = ADDR_W'(msf_frequency >> LOW_SHIFT);

    // A trigger is only honoured when no scan is in flight.
    assign trigger = (state_q == IDLE) && !busy_q &&
                     (scan_start ||
                      (enable && one_sec_marker && !marker_q &&
                       (second_counter == 6'(SCAN_SECOND))));

    assign span   = trk_max - trk_min;
    assign accept = span >= DATA_W'(MIN_CONTRAST);

    // Scan sequencer: issue every address, then let reads drain.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        last_d  = last_q;
        drain_d = drain_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    last_d  = last_index;
                    clear   = 1'b1;
                end
            end
            ISSUE: begin
                if (addr_q == last_q) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    en_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 3'(RD_LATENCY - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and marker edge history.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            en_q     <= 1'b0;
            last_q   <= '0;
            drain_q  <= '0;
            marker_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            last_q   <= last_d;
            drain_q  <= drain_d;
            marker_q <= one_sec_marker;
        end
    end

    // Valid/index pipeline aligned to the BRAM read latency.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_sr_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                idx_sr_q[i] <= '0;
            end
        end else begin
            vld_sr_q[0] <= en_q;
            idx_sr_q[0] <= addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
                idx_sr_q[i] <= idx_sr_q[i-1];
            end
        end
    end

    msf_minmax_track #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_track (
        .clk       (clk),
        .aresetn   (aresetn),
        .clear_i   (clear),
        .valid_i   (vld_sr_q[RD_LATENCY-1]),
        .index_i   (idx_sr_q[RD_LATENCY-1]),
        .data_i    (bram_rdata),
        .min_o     (trk_min),
        .max_o     (trk_max),
        .min_idx_o (trk_idx)
    );

    // Results move to the outputs only when the scan completes.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            low_time_q  <= '0;
            lt_valid_q  <= 1'b0;
            min_value_q <= '0;
            rejected_q  <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (trigger) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
            if (state_q == DONE) begin
                min_value_q <= trk_min;
                if (accept) begin
                    low_time_q <= slot_to_carrier(17'(trk_idx), LOW_SHIFT);
                    lt_valid_q <= 1'b1;
                    rejected_q <= 1'b0;
                end else begin
                    rejected_q <= 1'b1;
                end
            end
        end
    end

    assign bram_addr      = addr_q;
    assign bram_en        = en_q;
    assign low_time       = low_time_q;
    assign low_time_valid = lt_valid_q;
    assign min_value      = min_value_q;
    assign scan_busy      = busy_q;
    assign scan_done      = done_q;
    assign scan_rejected  = rejected_q;

endmodule

// File: tb/tb_msf_low_time_scan.sv
// Self-checking bench for msf_low_time_scan: BRAM model,
// vector table and scoreboard of expected scan results.
module tb_msf_low_time_scan;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        scan_start;
    logic        one_sec_marker;
    logic [5:0]  second_counter;
    logic [16:0] msf_frequency;
    logic [9:0]  bram_addr;
    logic        bram_en;
    logic [31:0] bram_rdata;
    logic [16:0] low_time;
    logic        low_time_valid;
    logic [31:0] min_value;
    logic        scan_busy;
    logic        scan_done;
    logic        scan_rejected;

    always #5 clk = ~clk;

    msf_low_time_scan dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .enable         (enable),
        .scan_start     (scan_start),
        .one_sec_marker (one_sec_marker),
        .second_counter (second_counter),
        .msf_frequency  (msf_frequency),
        .bram_addr      (bram_addr),
        .bram_en        (bram_en),
        .bram_rdata     (bram_rdata),
        .low_time       (low_time),
        .low_time_valid (low_time_valid),
        .min_value      (min_value),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .scan_rejected  (scan_rejected)
    );

    // Two-cycle read BRAM model
    logic [31:0] mem [1024];
    logic [31:0] rd_p0, rd_p1;
    always @(posedge clk) begin
        rd_p0 <= mem[bram_addr];
        rd_p1 <= rd_p0;
    end
    assign bram_rdata = rd_p1;

    typedef struct {
        logic [16:0] lt;
        logic [31:0] mv;
        logic        rej;
        logic        vld;
    } exp_t;

    typedef struct {
        string name;
        bit    ramp;
        int    flat;
        int    sa;
        int    va;
        int    sb;
        int    vb;
        int    freq;
        int    lt;
        int    mv;
        bit    rej;
        int    lat;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[9];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every scan_done must match the oldest expectation
    always @(negedge clk) begin
        if (aresetn && scan_done) begin
            n_done++;
            if (sbq.size() == 0) begin
                chk("unexpected_scan_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("low_time", low_time, mon_e.lt);
                chk("min_value", min_value, mon_e.mv);
                chk("scan_rejected", scan_rejected, mon_e.rej);
                chk("low_time_valid", low_time_valid, mon_e.vld);
            end
        end
    end

    task automatic fill(bit ramp, int flat, int sa, int va,
                        int sb, int vb);
        for (int i = 0; i < 1024; i++) begin
            mem[i] = ramp ? 32'(1000 - i) : 32'(flat);
        end
        if (sa >= 0) mem[sa] = 32'(va);
        if (sb >= 0) mem[sb] = 32'(vb);
    endtask

    task automatic run_scan(string nm, int freq, exp_t e, int lat);
        int cnt;
        msf_frequency = 17'(freq);
        sbq.push_back(e);
        @(negedge clk);
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        cnt = 1;
        while (!scan_done && cnt < 3000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({nm, "_latency"}, cnt, lat);
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic exp_t mk(int lt, int mv, bit rej, bit vld);
        exp_t e;
        e.lt  = 17'(lt);
        e.mv  = 32'(mv);
        e.rej = rej;
        e.vld = vld;
        return e;
    endfunction

    initial begin
        exp_t e;
        int   d0;
        int   cnt;

        vt[0] = '{"ramp_min300", 1, 0, 300, 5, -1, 0, 77499, 38400, 5, 0, 610};
        vt[1] = '{"tie_100_400", 1, 0, 100, 0, 400, 0, 77499, 12800, 0, 0, 610};
        vt[2] = '{"flat_reject", 0, 500, 10, 600, -1, 0, 77499, 12800, 500, 1, 610};
        vt[3] = '{"min_last_slot", 1, 0, 605, 1, -1, 0, 77499, 77440, 1, 0, 610};
        vt[4] = '{"beyond_last", 1, 0, 606, 0, -1, 0, 77499, 77440, 395, 0, 610};
        vt[5] = '{"single_entry", 1, 0, -1, 0, -1, 0, 100, 77440, 1000, 1, 5};
        vt[6] = '{"min_slot0", 1, 0, 0, 0, -1, 0, 77499, 0, 0, 0, 610};
        vt[7] = '{"contrast_255", 0, 500, 0, 755, -1, 0, 77499, 0, 500, 1, 610};
        vt[8] = '{"contrast_256", 0, 500, 0, 756, -1, 0, 77499, 128, 500, 0, 610};

        aresetn        = 1'b0;
        enable         = 1'b0;
        scan_start     = 1'b0;
        one_sec_marker = 1'b0;
        second_counter = 6'd0;
        msf_frequency  = 17'd77499;
        fill(1, 0, -1, 0, -1, 0);
        #23;
        chk("rst_low_time", low_time, 0);
        chk("rst_valid", low_time_valid, 0);
        chk("rst_min_value", min_value, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_rejected", scan_rejected, 0);
        chk("rst_bram_en", bram_en, 0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            fill(vt[k].ramp, vt[k].flat, vt[k].sa, vt[k].va,
                 vt[k].sb, vt[k].vb);
            run_scan(vt[k].name, vt[k].freq,
                     mk(vt[k].lt, vt[k].mv, vt[k].rej, 1), vt[k].lat);
        end

        // Automatic trigger: only a rising marker at second 0 with enable
        fill(0, 500, -1, 0, -1, 0);
        msf_frequency = 17'd100;
        for (int pass = 0; pass < 2; pass++) begin
            enable = (pass == 1);
            for (int s = 57; s < 63; s++) begin
                @(negedge clk);
                second_counter = 6'(s % 60);
                if (enable && (s % 60) == 0) sbq.push_back(mk(128, 500, 1, 1));
                one_sec_marker = 1'b1;
                repeat (3) @(negedge clk);
                chk($sformatf("auto_busy_p%0d_s%0d", pass, s % 60), scan_busy,
                    (enable && (s % 60) == 0));
                repeat (4) @(negedge clk);
                one_sec_marker = 1'b0;
                repeat (6) @(negedge clk);
            end
        end
        enable = 1'b0;
        chk("auto_queue_empty", sbq.size(), 0);

        // Repeated scan_start while busy yields a single scan
        d0 = n_done;
        sbq.push_back(mk(128, 500, 1, 1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            scan_start = 1'b1;
        end
        @(negedge clk);
        scan_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("multi_start_dones", n_done - d0, 1);

        // Reset mid-scan aborts, later scan completes
        fill(1, 0, 300, 5, -1, 0);
        msf_frequency = 17'd77499;
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        cnt = 0;
        while (bram_addr != 10'd200 && cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("abort_reach_addr200", bram_addr, 200);
        aresetn = 1'b0;
        #1;
        chk("abort_low_time", low_time, 0);
        chk("abort_valid", low_time_valid, 0);
        chk("abort_min_value", min_value, 0);
        chk("abort_busy", scan_busy, 0);
        chk("abort_rejected", scan_rejected, 0);
        chk("abort_bram_en", bram_en, 0);
        chk("abort_bram_addr", bram_addr, 0);
        @(negedge clk);
        aresetn = 1'b1;
        d0 = n_done;
        repeat (700) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_idle_busy", scan_busy, 0);
        run_scan("after_abort", 77499, mk(38400, 5, 0, 1), 610);
        chk("final_queue_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
